// File: rtl/boot_seq_pkg.sv
// rtl/boot_seq_pkg.sv - sequencer state encoding and default cycle constants
package boot_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DETACH = 2'd1,
    ST_REBOOT = 2'd2,
    ST_HALT   = 2'd3
  } seq_state_e;

  localparam int unsigned POR_CYCLES_DEF      = 4800000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 480000;
  localparam int unsigned DETACH_CYCLES_DEF   = 480000;
  localparam int unsigned PROGN_CYCLES_DEF    = 48;
  localparam int unsigned HB_CNT_W            = 23;

  // A zero-length interval makes no sense for any counter here, so it is promoted to one cycle.
  function automatic int unsigned min_one(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer plus saturating debounce for the user reset button
module btn_debounce
  import boot_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic btn_db
);

  localparam int unsigned DB_N  = min_one(DEBOUNCE_CYCLES);
  localparam int unsigned CNT_W = $clog2(DB_N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_N - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Counts consecutive samples that disagree with the accepted value; any agreeing sample restarts it.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - POR/button reset generation and USB-detach/PROGN reboot sequencer
// Optional heartbeat LED output enabled by defining BOOT_SEQ_HEARTBEAT_EN.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int unsigned POR_CYCLES      = POR_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned DETACH_CYCLES   = DETACH_CYCLES_DEF,
  parameter int unsigned PROGN_CYCLES    = PROGN_CYCLES_DEF
) (
  input  logic clk_48mhz,
  input  logic reset_n,
  input  logic btn_reset,
  input  logic boot,
  output logic bl_reset,
  output logic usb_detach,
  output logic progn_n
`ifdef BOOT_SEQ_HEARTBEAT_EN
  ,
  output logic hb_led
`endif
);

  localparam int unsigned POR_N = min_one(POR_CYCLES);
  localparam int unsigned DET_N = min_one(DETACH_CYCLES);
  localparam int unsigned PRG_N = min_one(PROGN_CYCLES);
  localparam int unsigned POR_W = $clog2(POR_N + 1);
  localparam int unsigned DET_W = $clog2(DET_N + 1);
  localparam int unsigned PRG_W = $clog2(PRG_N + 1);
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_N);
  localparam logic [DET_W-1:0] DET_LAST = DET_W'(DET_N - 1);
  localparam logic [PRG_W-1:0] PRG_LAST = PRG_W'(PRG_N - 1);

  seq_state_e       state_q, state_d;
  logic [POR_W-1:0] por_cnt_q, por_cnt_d;
  logic [DET_W-1:0] det_cnt_q, det_cnt_d;
  logic [PRG_W-1:0] prg_cnt_q, prg_cnt_d;
  logic             bl_reset_q, bl_reset_d;
  logic             boot_prev_q, boot_prev_d;
  logic             usb_detach_q, usb_detach_d;
  logic             progn_n_q, progn_n_d;
  logic             btn_db;
  logic             por_running;
  logic             boot_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk_48mhz),
    .rst_n    (reset_n),
    .btn_async(btn_reset),
    .btn_db   (btn_db)
  );

  assign por_running = (por_cnt_q != POR_LAST);
  assign boot_rise   = boot & ~boot_prev_q;

  always_comb begin
    por_cnt_d   = por_running ? por_cnt_q + POR_W'(1) : por_cnt_q;
    bl_reset_d  = por_running | btn_db;
    boot_prev_d = boot;
    state_d     = state_q;
    det_cnt_d   = '0;
    prg_cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (boot_rise && !por_running) state_d = ST_DETACH;
      end
      ST_DETACH: begin
        // A button press cancels the detach before the FPGA is ever told to reconfigure.
        if (btn_db) begin
          state_d = ST_IDLE;
        end else if (det_cnt_q == DET_LAST) begin
          state_d = ST_REBOOT;
        end else begin
          det_cnt_d = det_cnt_q + DET_W'(1);
        end
      end
      ST_REBOOT: begin
        if (prg_cnt_q == PRG_LAST) begin
          state_d = ST_HALT;
        end else begin
          prg_cnt_d = prg_cnt_q + PRG_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pad controls are registered from the next state so they never glitch on a state decode.
    usb_detach_d = (state_d != ST_IDLE);
    progn_n_d    = (state_d != ST_REBOOT);
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      por_cnt_q    <= '0;
      det_cnt_q    <= '0;
      prg_cnt_q    <= '0;
      bl_reset_q   <= 1'b1;
      boot_prev_q  <= 1'b0;
      usb_detach_q <= 1'b0;
      progn_n_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      por_cnt_q    <= por_cnt_d;
      det_cnt_q    <= det_cnt_d;
      prg_cnt_q    <= prg_cnt_d;
      bl_reset_q   <= bl_reset_d;
      boot_prev_q  <= boot_prev_d;
      usb_detach_q <= usb_detach_d;
      progn_n_q    <= progn_n_d;
    end
  end

  assign bl_reset   = bl_reset_q;
  assign usb_detach = usb_detach_q;
  assign progn_n    = progn_n_q;

`ifdef BOOT_SEQ_HEARTBEAT_EN
  logic [HB_CNT_W-1:0] hb_cnt_q, hb_cnt_d;
  logic                hb_led_q, hb_led_d;

  always_comb begin
    hb_cnt_d = '0;
    hb_led_d = 1'b1;
    if (state_d == ST_IDLE) begin
      hb_led_d = hb_led_q;
      if (&hb_cnt_q) begin
        hb_led_d = ~hb_led_q;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q <= '0;
      hb_led_q <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_led_q <= hb_led_d;
    end
  end

  assign hb_led = hb_led_q;
`endif

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 The block SHALL have parameter POR_CYCLES, default 4800000, meaning cycles that bl_reset is held after reset release (100 ms at 48 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 480000, meaning consecutive stable samples needed to accept a button change.
REQ-003 The block SHALL have parameter DETACH_CYCLES, default 480000, meaning cycles usb_detach is held before reboot.
REQ-004 The block SHALL have parameter PROGN_CYCLES, default 48, meaning width of the progn_n low pulse.
REQ-005 The block SHALL have port clk_48mhz  input  1  single clock for all logic.
REQ-006 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port btn_reset  input  1  raw, asynchronous, active-high user reset button.
REQ-008 The block SHALL have port boot  input  1  bootloader request to start the user image, synchronous to clk_48mhz.
REQ-009 The block SHALL have port bl_reset  output  1  active-high reset to the bootloader core.
REQ-010 The block SHALL have port usb_detach  output  1  forces the USB pads to tri-state or SE0 so the host sees a disconnect.
REQ-011 The block SHALL have port progn_n  output  1  active-low FPGA reconfiguration request.

Function
REQ-012 btn_reset SHALL pass through a 2-flop synchronizer before debounce; the debounced value btn_db SHALL change only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-013 The POR counter SHALL hold bl_reset=1 for exactly POR_CYCLES cycles after reset_n deasserts; thereafter bl_reset SHALL equal btn_db, registered with 1 cycle latency.
REQ-014 The sequencer SHALL have states IDLE, DETACH, REBOOT and HALT.
REQ-015 In IDLE, a rising edge of boot (0 in the previous cycle, 1 now) while the POR counter is not running SHALL move the sequencer to DETACH on the next edge; boot edges during POR SHALL be ignored.
REQ-016 DETACH SHALL assert usb_detach=1 for DETACH_CYCLES cycles and then go to REBOOT.
REQ-017 btn_db=1 during DETACH SHALL abort to IDLE and clear usb_detach on the next cycle.
REQ-018 REBOOT SHALL drive progn_n=0 for PROGN_CYCLES cycles with usb_detach still 1, then go to HALT.
REQ-019 HALT SHALL hold progn_n=1 and usb_detach=1, ignore boot and btn_db, and be left only by reset_n.
REQ-020 Counters SHALL be sized $clog2(N+1) for their parameter and SHALL saturate, never wrap; parameter values of 0 SHALL be treated as 1.
REQ-021 A boot that stays high SHALL not retrigger; only a new 0-to-1 edge is accepted.

Reset
REQ-022 While reset_n=0, outputs SHALL be bl_reset=1, usb_detach=0, progn_n=1 and hb_led=0, the state SHALL be IDLE, and all counters and synchronizer flops SHALL be 0.
REQ-023 Asserting reset_n mid-sequence (DETACH or REBOOT) SHALL immediately restore the REQ-022 values, including releasing progn_n.

Configuration
REQ-024 With macro BOOT_SEQ_HEARTBEAT_EN defined, the block SHALL add output hb_led (1 bit) that toggles every 2^23 cycles in IDLE and is held at 1 in DETACH, REBOOT and HALT.
REQ-025 Without BOOT_SEQ_HEARTBEAT_EN, the block SHALL have no hb_led port and no heartbeat counter.

Structure
REQ-026 The state encoding and the default cycle constants SHALL reside in package boot_seq_pkg.
REQ-027 The synchronizer plus debounce SHALL be a sub-module, btn_debounce, parameterized by DEBOUNCE_CYCLES.

Verification (POR_CYCLES=8, DEBOUNCE_CYCLES=4, DETACH_CYCLES=10, PROGN_CYCLES=3)
REQ-028 Bench SHALL cover: release reset_n -> bl_reset=1 for exactly 8 cycles, then 0.
REQ-029 Bench SHALL cover: btn_reset=1 for 3 cycles -> bl_reset stays 0; btn_reset=1 for 6 cycles -> bl_reset=1 starting 2+4+1 cycles after the press.
REQ-030 Bench SHALL cover: boot pulse after POR -> usb_detach=1 for 10 cycles, then progn_n=0 for 3 cycles, then HALT with progn_n=1 and usb_detach=1; a later boot pulse causes no change.
REQ-031 Bench SHALL cover: boot pulse during POR cycle 5 -> state remains IDLE and usb_detach stays 0.
REQ-032 Bench SHALL cover: boot pulse, then a debounced button press in DETACH cycle 4 -> usb_detach=0 and progn_n never goes low; a new boot edge restarts the sequence.
REQ-033 Bench SHALL cover: reset_n asserted during REBOOT -> progn_n=1, usb_detach=0 and bl_reset=1 in the same cycle.
